// File: rtl/cache_rd_arb_pkg.sv
// cache_rd_arb_pkg
// Shared definitions for the cache read arbiter: FSM state encoding, grant
// encoding, dcache read-type codes and AXI burst constants.
// Imported by cache_rd_arb_pick and cache_rd_arbiter.
package cache_rd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    // d_r_type codes; any code not listed is handled as a word read
    localparam logic [2:0] TYPE_BYTE = 3'd0;
    localparam logic [2:0] TYPE_HALF = 3'd1;
    localparam logic [2:0] TYPE_WORD = 3'd2;
    localparam logic [2:0] TYPE_LINE = 3'd4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/cache_rd_arb_pick.sv
// cache_rd_arb_pick
// Combinational grant choice between the icache and dcache read requests.
// Ports:
//   i_req   in  icache request pending
//   d_req   in  dcache request pending
//   last_d  in  1 = dcache was served last (0 = icache / tied off)
//   gnt     out chosen requester, GNT_NONE when nobody asks
// With last_d tied to 0 this reduces to fixed dcache priority.
module cache_rd_arb_pick
    import cache_rd_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_d,
    output gnt_e gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (i_req && d_req) begin
            // conflict: favour whoever was not served last
            gnt = last_d ? GNT_I : GNT_D;
        end else if (d_req) begin
            gnt = GNT_D;
        end else if (i_req) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter
// Shares one AXI read channel between the icache refill port and the dcache
// read port. One requester is granted at a time, one AR burst is issued, and
// the R beats are steered back to the granted requester only. One
// transaction outstanding at a time.
//
// Ports:
//   clk, rstn                     clock, async active-low reset
//   i_r_req/i_r_addr              icache line-read request (held until i_r_rdy)
//   i_r_data_ready                icache accepts R beat
//   i_r_rdy                       AR accepted for icache (1-cycle pulse)
//   i_ret_valid/i_ret_last        icache beat valid / last beat
//   d_r_req/d_r_addr/d_r_type     dcache request (byte/half/word/line)
//   d_r_data_ready                dcache accepts R beat
//   d_r_rdy                       AR accepted for dcache (1-cycle pulse)
//   d_ret_valid/d_ret_last        dcache beat valid / last beat
//   ret_data                      R data shared by both requesters
//   araddr/arlen/arsize/arburst/arvalid/arready   AXI AR channel
//   rdata/rvalid/rlast/rready     AXI R channel
//
// Build option: CACHE_RD_ARB_RR_EN selects round-robin arbitration using a
// last-served bit; without it the dcache has fixed priority.
module cache_rd_arbiter
    import cache_rd_arb_pkg::*;
#(
    parameter int LINE_WORDS = 16,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              i_r_req,
    input  logic [ADDR_W-1:0] i_r_addr,
    input  logic              i_r_data_ready,
    output logic              i_r_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,

    input  logic              d_r_req,
    input  logic [ADDR_W-1:0] d_r_addr,
    input  logic [2:0]        d_r_type,
    input  logic              d_r_data_ready,
    output logic              d_r_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,

    output logic [31:0]       ret_data,

    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,

    input  logic [31:0]       rdata,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready
);

    // byte offset bits inside a cache line
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    gnt_e              pick_gnt;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [2:0]        arsize_q, arsize_d;

    logic              last_srv;   // 1 = dcache was served last
    logic              beat_last;  // final beat of the burst is accepted

    // AR fields for the requester that would win this cycle
    logic [ADDR_W-1:0] req_addr;
    logic              req_line;
    logic [2:0]        req_size;

    //--------------------------------------------------------------------
    // Arbitration
    //--------------------------------------------------------------------
    cache_rd_arb_pick u_pick (
        .i_req  (i_r_req),
        .d_req  (d_r_req),
        .last_d (last_srv),
        .gnt    (pick_gnt)
    );

`ifdef CACHE_RD_ARB_RR_EN
    logic last_srv_q, last_srv_d;

    always_comb begin
        last_srv_d = last_srv_q;
        if (beat_last) begin
            last_srv_d = (gnt_q == GNT_D);
        end
    end

    // reset to "icache served last" so the dcache takes the first conflict
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_srv_q <= 1'b0;
        end else begin
            last_srv_q <= last_srv_d;
        end
    end

    assign last_srv = last_srv_q;
`else
    // no history: conflicts always go to the dcache
    assign last_srv = 1'b0;
`endif

    //--------------------------------------------------------------------
    // AR field decode for the winning request
    //--------------------------------------------------------------------
    always_comb begin
        req_addr = d_r_addr;
        req_line = 1'b0;
        req_size = SIZE_WORD;
        if (pick_gnt == GNT_I) begin
            // icache only ever refills whole lines
            req_addr = i_r_addr;
            req_line = 1'b1;
        end else begin
            case (d_r_type)
                TYPE_BYTE: req_size = SIZE_BYTE;
                TYPE_HALF: req_size = SIZE_HALF;
                TYPE_LINE: req_line = 1'b1;
                default:   req_size = SIZE_WORD;
            endcase
        end
    end

    assign beat_last = (state_q == R) && rvalid && rready && rlast;

    //--------------------------------------------------------------------
    // FSM next state and latched AR fields
    //--------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        case (state_q)
            IDLE: begin
                if (pick_gnt != GNT_NONE) begin
                    gnt_d    = pick_gnt;
                    araddr_d = req_line ? {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                        : req_addr;
                    arlen_d  = req_line ? LINE_LEN : 8'd0;
                    arsize_d = req_line ? SIZE_WORD : req_size;
                    state_d  = AR;
                end
            end
            AR: begin
                if (arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (beat_last) begin
                    gnt_d   = GNT_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = GNT_NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_NONE;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
        end
    end

    //--------------------------------------------------------------------
    // Outputs: everything is gated by state so an ungranted side and any
    // rvalid outside R never leak through.
    //--------------------------------------------------------------------
    always_comb begin
        arvalid     = 1'b0;
        rready      = 1'b0;
        i_r_rdy     = 1'b0;
        d_r_rdy     = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        case (state_q)
            AR: begin
                arvalid = 1'b1;
                // rdy follows arready in the same cycle as the handshake
                i_r_rdy = arready && (gnt_q == GNT_I);
                d_r_rdy = arready && (gnt_q == GNT_D);
            end
            R: begin
                if (gnt_q == GNT_I) begin
                    rready      = i_r_data_ready;
                    i_ret_valid = rvalid;
                    i_ret_last  = rvalid && rlast;
                end else if (gnt_q == GNT_D) begin
                    rready      = d_r_data_ready;
                    d_ret_valid = rvalid;
                    d_ret_last  = rvalid && rlast;
                end
            end
            default: ;
        endcase
    end

    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = AXI_BURST_INCR;
    assign ret_data = rdata;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
module tb_cache_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_r_req, i_r_data_ready, i_r_rdy, i_ret_valid, i_ret_last;
    logic [31:0] i_r_addr;
    logic        d_r_req, d_r_data_ready, d_r_rdy, d_ret_valid, d_ret_last;
    logic [31:0] d_r_addr;
    logic [2:0]  d_r_type;
    logic [31:0] ret_data, araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready, rvalid, rlast, rready;

    always #5 clk = ~clk;

    cache_rd_arbiter #(.LINE_WORDS(16), .ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_data_ready(i_r_data_ready),
        .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_type(d_r_type),
        .d_r_data_ready(d_r_data_ready), .d_r_rdy(d_r_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

`ifdef CACHE_RD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        is_d;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [2:0]  rtype;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [2:0]  exp_size;
        int          nbeats;
        int          ar_wait;
        int          stall_beat;
        int          stall_len;
    } vec_t;
    vec_t vecs[10];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // scoreboard: a beat handed to the DUT is compared when it is accepted
    always @(negedge clk) begin : mon
        beat_t e;
        if (rstn && rvalid && rready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: rdata 0x%0h accepted, none expected", rdata);
            end else begin
                e = sb.pop_front();
                chk("ret_data", ret_data, e.data);
                chk1("ret_valid_win", e.is_d ? d_ret_valid : i_ret_valid, 1'b1);
                chk1("ret_last_win", e.is_d ? d_ret_last : i_ret_last, e.last);
                chk1("ret_valid_other", e.is_d ? (i_ret_valid | i_ret_last)
                                               : (d_ret_valid | d_ret_last), 1'b0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_arvalid"}, arvalid, 1'b0);
        chk1({tag, "_rready"}, rready, 1'b0);
        chk({tag, "_rdy"}, 32'({i_r_rdy, d_r_rdy}), 32'd0);
        chk({tag, "_ret"}, 32'({i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}), 32'd0);
        chk({tag, "_araddr"}, araddr, 32'd0);
        chk({tag, "_arlen"}, 32'(arlen), 32'd0);
        chk({tag, "_arsize"}, 32'(arsize), 32'd0);
        chk({tag, "_arburst"}, 32'(arburst), 32'd1);
    endtask

    // Called at posedge+1 after the request is driven; serves one burst.
    task automatic serve(input logic is_d, input logic [31:0] exp_addr,
                         input logic [7:0] exp_len, input logic [2:0] exp_size,
                         input int nbeats, input int ar_wait,
                         input int stall_beat, input int stall_len,
                         input bit keep_req, input bit no_last, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        chk1("arvalid_rise", arvalid, 1'b1);
        if (!arvalid) return;
        chk("araddr", araddr, exp_addr);
        chk("arlen", 32'(arlen), 32'(exp_len));
        chk("arsize", 32'(arsize), 32'(exp_size));
        chk("arburst", 32'(arburst), 32'd1);
        repeat (ar_wait) begin
            @(posedge clk); #1;
            // requester inputs wander; latched fields must not
            i_r_addr = $urandom;
            d_r_addr = $urandom;
            d_r_type = 3'($urandom_range(0, 7));
            @(negedge clk);
            chk1("arvalid_hold", arvalid, 1'b1);
            chk("araddr_hold", araddr, exp_addr);
            chk("arlen_hold", 32'(arlen), 32'(exp_len));
            chk("rdy_early", 32'({i_r_rdy, d_r_rdy}), 32'd0);
        end
        @(posedge clk); #1;
        arready = 1'b1;
        @(negedge clk);
        chk1("r_rdy_win", is_d ? d_r_rdy : i_r_rdy, 1'b1);
        chk1("r_rdy_lose", is_d ? i_r_rdy : d_r_rdy, 1'b0);
        @(posedge clk); #1;
        arready = 1'b0;
        if (!keep_req) begin
            if (is_d) d_r_req = 1'b0;
            else      i_r_req = 1'b0;
        end
        @(negedge clk);
        chk("r_rdy_pulse", 32'({i_r_rdy, d_r_rdy}), 32'd0);
        chk1("arvalid_drop", arvalid, 1'b0);
        @(posedge clk); #1;
        for (int b = 0; b < nbeats; b++) begin
            rvalid = 1'b1;
            rdata  = $urandom;
            rlast  = !no_last && (b == nbeats - 1);
            if (b == stall_beat) begin
                if (is_d) d_r_data_ready = 1'b0;
                else      i_r_data_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    chk1("rready_stall", rready, 1'b0);
                    chk1("ret_valid_stall", is_d ? d_ret_valid : i_ret_valid, 1'b1);
                    @(posedge clk); #1;
                end
                i_r_data_ready = 1'b1;
                d_r_data_ready = 1'b1;
            end
            sb.push_back('{rdata, rlast, is_d});
            @(posedge clk); #1;
        end
        if (!no_last) begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            @(negedge clk);
            chk("sb_drained", 32'(sb.size()), 32'd0);
            chk1("idle_gap_arvalid", arvalid, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs[0] = '{1'b0, 32'h1C000104, 3'd0, 32'h1C000100, 8'd15, 3'd2, 16, 0, -1, 0};
        vecs[1] = '{1'b1, 32'h00000003, 3'd0, 32'h00000003, 8'd0,  3'd0, 1,  0, -1, 0};
        vecs[2] = '{1'b1, 32'h00001002, 3'd1, 32'h00001002, 8'd0,  3'd1, 1,  0, -1, 0};
        vecs[3] = '{1'b1, 32'h00002004, 3'd2, 32'h00002004, 8'd0,  3'd2, 1,  0, -1, 0};
        vecs[4] = '{1'b1, 32'h8000007C, 3'd4, 32'h80000040, 8'd15, 3'd2, 16, 0, -1, 0};
        vecs[5] = '{1'b1, 32'h00000ABC, 3'd3, 32'h00000ABC, 8'd0,  3'd2, 1,  0, -1, 0};
        vecs[6] = '{1'b1, 32'h00000ABD, 3'd7, 32'h00000ABD, 8'd0,  3'd2, 1,  0, -1, 0};
        vecs[7] = '{1'b0, 32'h0000003F, 3'd0, 32'h00000000, 8'd15, 3'd2, 16, 5, -1, 0};
        vecs[8] = '{1'b1, 32'h44444444, 3'd2, 32'h44444444, 8'd0,  3'd2, 1,  0, 0,  3};
        vecs[9] = '{1'b0, 32'h12345678, 3'd0, 32'h12345640, 8'd15, 3'd2, 16, 0, 5,  4};

        i_r_req = 0; i_r_addr = 0; i_r_data_ready = 1;
        d_r_req = 0; d_r_addr = 0; d_r_type = 0; d_r_data_ready = 1;
        arready = 0; rdata = 0; rvalid = 0; rlast = 0;

        #12;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rstn = 1'b1;

        // stray rvalid while idle must not be accepted or forwarded
        rvalid = 1'b1;
        rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk1("idle_rready", rready, 1'b0);
        chk("idle_ret", 32'({i_ret_valid, d_ret_valid}), 32'd0);
        @(posedge clk); #1;
        rvalid = 1'b0;

        // single-requester vectors
        for (int v = 0; v < 10; v++) begin
            @(posedge clk); #1;
            if (vecs[v].is_d) begin
                d_r_req  = 1'b1;
                d_r_addr = vecs[v].addr;
                d_r_type = vecs[v].rtype;
            end else begin
                i_r_req  = 1'b1;
                i_r_addr = vecs[v].addr;
            end
            serve(vecs[v].is_d, vecs[v].exp_addr, vecs[v].exp_len, vecs[v].exp_size,
                  vecs[v].nbeats, vecs[v].ar_wait, vecs[v].stall_beat,
                  vecs[v].stall_len, 1'b0, 1'b0, lat);
            chk("req_to_arvalid", 32'(lat), 32'd1);
        end

        // same-cycle conflicts, twice in a row, from a fresh reset
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        i_r_req = 1'b1; i_r_addr = 32'h00001010;
        d_r_req = 1'b1; d_r_addr = 32'h20000008; d_r_type = 3'd2;
        serve(1'b1, 32'h20000008, 8'd0, 3'd2, 1, 0, -1, 0, 1'b1, 1'b0, lat);
        if (RR) begin
            serve(1'b0, 32'h00001000, 8'd15, 3'd2, 16, 0, -1, 0, 1'b0, 1'b0, lat);
            serve(1'b1, 32'h20000008, 8'd0, 3'd2, 1, 0, -1, 0, 1'b0, 1'b0, lat);
        end else begin
            serve(1'b1, 32'h20000008, 8'd0, 3'd2, 1, 0, -1, 0, 1'b0, 1'b0, lat);
            serve(1'b0, 32'h00001000, 8'd15, 3'd2, 16, 0, -1, 0, 1'b0, 1'b0, lat);
        end

        // reset in the middle of a burst, after beat 7
        @(posedge clk); #1;
        i_r_req  = 1'b1;
        i_r_addr = 32'h1C000200;
        serve(1'b0, 32'h1C000200, 8'd15, 3'd2, 7, 0, -1, 0, 1'b0, 1'b1, lat);
        #2;
        rvalid = 1'b1;
        rlast  = 1'b0;
        rstn   = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        rvalid = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        d_r_req  = 1'b1;
        d_r_addr = 32'h00000003;
        d_r_type = 3'd0;
        serve(1'b1, 32'h00000003, 8'd0, 3'd0, 1, 0, -1, 0, 1'b0, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_rd_arbiter.md
# cache_rd_arbiter

Shares the single AXI read channel of the core between the instruction-cache refill port and the data-cache read port. Each requester uses the cache-side handshake (r_req / r_rdy / ret_valid / ret_last); the arbiter grants one requester at a time, issues one AR burst, and steers the R beats back to the granted requester only. It sits between the two cache controllers and the AXI bridge, with one outstanding transaction at a time.

## Interface
- LINE_WORDS, 16: words per cache line; a line read uses arlen = LINE_WORDS-1.
- ADDR_W, 32: address width.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_r_req  in  1  icache read request; held until i_r_rdy.
- i_r_addr  in  ADDR_W  icache line address; always a line read.
- i_r_data_ready  in  1  icache accepts R beat.
- i_r_rdy  out  1  AR handshake done for icache (1-cycle pulse).
- i_ret_valid / i_ret_last  out  1 / 1  beat valid / last beat, icache.
- d_r_req  in  1  dcache read request; held until d_r_rdy.
- d_r_addr  in  ADDR_W  dcache address.
- d_r_type  in  3  0 byte, 1 half, 2 word, 4 line; other codes treated as word.
- d_r_data_ready  in  1  dcache accepts R beat.
- d_r_rdy  out  1  AR handshake done for dcache (1-cycle pulse).
- d_ret_valid / d_ret_last  out  1 / 1  beat valid / last beat, dcache.
- ret_data  out  32  R data, shared by both requesters; qualified by the *_ret_valid signals.
- araddr  out  ADDR_W; arlen  out  8; arsize  out  3; arburst  out  2 (fixed INCR 2'b01); arvalid  out  1; arready  in  1.
- rdata  in  32; rvalid  in  1; rlast  in  1; rready  out  1.

## Operation
- FSM states: IDLE, AR, R.
- IDLE: if any *_r_req, pick a winner. Latch grant, araddr, arlen, arsize; go to AR.
- AR: arvalid=1 with the latched fields. When arready=1, pulse the granted *_r_rdy in the same cycle (combinational from arready), then go to R.
- R: rready = granted *_r_data_ready. Granted *_ret_valid = rvalid. Granted *_ret_last = rvalid & rlast. ret_data = rdata. On rvalid & rready & rlast, go to IDLE.
- Ungranted requester: *_r_rdy, *_ret_valid and *_ret_last stay 0. Its request stays pending.
- AR field encoding:
  - line (icache or d_r_type=4): arlen=LINE_WORDS-1, arsize=2.
  - byte / half / word: arlen=0, arsize = 0 / 1 / 2.
  - Line address: low log2(LINE_WORDS*4) bits forced to 0. Other types pass the address unchanged.
- Default arbitration is fixed priority: dcache wins when both request in the same IDLE cycle.
- A request that arrives while not in IDLE waits; it is sampled in the next IDLE cycle.
- rvalid outside state R: rready=0 and no beat is forwarded.

## Timing
- Reset values: state=IDLE, grant=none, arvalid=0, rready=0, all *_r_rdy / *_ret_* = 0, araddr=0, arlen=0, arsize=0. arburst is constant 2'b01.
- Request to arvalid: 1 cycle (req seen in cycle N, arvalid=1 in N+1).
- Last beat to the next arvalid: at least 2 cycles (IDLE occupies one cycle).
- Latched AR fields do not change while arvalid=1, even if the requester's inputs change.
- Reset mid-transaction returns to IDLE immediately. The system resets the AXI slave in the same event.

## Configuration
- CACHE_RD_ARB_RR_EN defined: round-robin arbitration.
  - A last-served bit updates when a transaction's last beat is accepted.
  - On a same-cycle conflict, grant the requester that was not served last.
  - Reset value of the bit = icache, so dcache wins the first conflict.
- CACHE_RD_ARB_RR_EN undefined: fixed dcache priority as above; no last-served bit.

## Structure
- Shared package holds:
  - state encodings IDLE/AR/R;
  - r_type codes (TYPE_BYTE=0, TYPE_HALF=1, TYPE_WORD=2, TYPE_LINE=4);
  - AXI_BURST_INCR=2'b01;
  - grant encoding (GNT_I, GNT_D).
- One sub-module, cache_rd_arb_pick: combinational grant choice from i_r_req, d_r_req and the last-served bit (the bit is tied off when round-robin is compiled out).

## Test plan
- Icache alone, i_r_addr=0x1C000104, arready held 1, 16 beats with rlast on the 16th:
  - araddr=0x1C000100, arlen=15, arsize=2;
  - i_r_rdy pulses once;
  - 16 i_ret_valid beats, i_ret_last on beat 16;
  - d_* outputs stay 0.
- Dcache byte read, d_r_type=0, addr 0x00000003: araddr=0x3, arlen=0, arsize=0, one beat with d_ret_last=1.
- Both requesters assert in the same cycle, twice in a row:
  - fixed build: dcache granted both times;
  - CACHE_RD_ARB_RR_EN build: dcache, then icache.
- Backpressure:
  - arready low for 5 cycles: arvalid and araddr stay stable, then one r_rdy pulse.
  - i_r_data_ready low: rready=0 and no beat is lost.
- rstn asserted mid-burst after beat 7: all outputs return to reset values asynchronously, and a new request afterwards starts a fresh AR.
